// File: rtl/keyboard_scan.sv
// keyboard_scan: synchronised, debounced scanner for KEY_NUM active-low keys with a press/release event FIFO.
// Optional build macro KEYBOARD_LAST_PRESS_EN: key_code follows the most recent press that is still held.
`timescale 1ns/1ps
module keyboard_scan #(
  parameter  int PCLK_FREQ    = 10_000_000,
  parameter  int SCAN_FREQ    = 1_000,
  parameter  int KEY_NUM      = 13,
  parameter  int DEBOUNCE_CNT = 4,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CW           = $clog2(KEY_NUM)
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key,
  output logic [KEY_NUM-1:0] key_state,
  output logic               key_valid,
  output logic [CW-1:0]      key_code,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [CW-1:0]      evt_code,
  output logic               evt_press,
  output logic               overflow
);

  localparam int TICK_DIV = PCLK_FREQ / SCAN_FREQ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = CW + 1;

  function automatic logic [CW-1:0] lowest_idx(input logic [KEY_NUM-1:0] v);
    logic [CW-1:0] idx;
    idx = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (v[i]) idx = CW'(i);
    end
    return idx;
  endfunction

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
  logic               tick_s;
  logic [3:0]         db_q [KEY_NUM];
  logic [3:0]         db_d [KEY_NUM];
  logic [KEY_NUM-1:0] key_state_q, key_state_d, chg_s;
  logic [KEY_NUM-1:0] chg_q, chg_d;
  logic               walk_busy_q, walk_busy_d;
  logic [CW-1:0]      walk_idx_q, walk_idx_d;
  logic               push_s;
  logic [EW-1:0]      push_data_s;
  logic [EW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               full_s, pop_s, wr_en_s;
  logic               evt_valid_q, overflow_q, overflow_d;
  logic               key_valid_q, key_valid_d;
  logic [CW-1:0]      key_code_q, key_code_d;
`ifdef KEYBOARD_LAST_PRESS_EN
  logic [CW-1:0]      last_q, last_d;
`endif

  // Two-flop synchroniser; inverted so a 1 means "pressed"
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~key;
      sync2_q <= sync1_q;
    end
  end

  // Scan tick divider
  always_comb begin
    tick_s = (tick_cnt_q == TW'(TICK_DIV - 1));
    if (tick_s) tick_cnt_d = '0;
    else        tick_cnt_d = tick_cnt_q + TW'(1);
  end

  // Per-key debounce: the DEBOUNCE_CNT-th consecutive differing sample flips the state
  always_comb begin
    db_d        = db_q;
    key_state_d = key_state_q;
    chg_s       = '0;
`ifdef KEYBOARD_LAST_PRESS_EN
    last_d      = last_q;
`endif
    for (int i = 0; i < KEY_NUM; i++) begin
      if (!tick_s) begin
        db_d[i] = db_q[i];
      end else if (sync2_q[i] == key_state_q[i]) begin
        db_d[i] = 4'd0;
      end else if (db_q[i] == 4'(DEBOUNCE_CNT - 1)) begin
        db_d[i]        = 4'd0;
        key_state_d[i] = ~key_state_q[i];
        chg_s[i]       = 1'b1;
`ifdef KEYBOARD_LAST_PRESS_EN
        if (!key_state_q[i]) last_d = CW'(i);
        else                 last_d = last_d;
`endif
      end else begin
        db_d[i] = db_q[i] + 4'd1;
      end
    end
  end

  // Change-vector walker: one index per cycle after each tick
  always_comb begin
    chg_d       = chg_q;
    walk_busy_d = walk_busy_q;
    walk_idx_d  = walk_idx_q;
    push_s      = 1'b0;
    push_data_s = {walk_idx_q, key_state_q[walk_idx_q]};
    if (tick_s) begin
      chg_d       = chg_s;
      walk_busy_d = 1'b1;
      walk_idx_d  = '0;
    end else if (walk_busy_q) begin
      push_s = chg_q[walk_idx_q];
      if (walk_idx_q == CW'(KEY_NUM - 1)) walk_busy_d = 1'b0;
      else                                walk_idx_d  = walk_idx_q + CW'(1);
    end else begin
      walk_busy_d = 1'b0;
    end
  end

  // FIFO control; a push into a full FIFO is only accepted alongside a pop
  always_comb begin
    full_s     = (count_q == (AW + 1)'(FIFO_DEPTH));
    pop_s      = (count_q != '0) && evt_ready;
    wr_en_s    = push_s && (!full_s || pop_s);
    overflow_d = overflow_q | (push_s && full_s && !pop_s);
    if (wr_en_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (pop_s) rd_ptr_d = rd_ptr_q + AW'(1);
    else       rd_ptr_d = rd_ptr_q;
    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Held-key summary, one registered stage behind key_state
  always_comb begin
    key_valid_d = |key_state_q;
`ifdef KEYBOARD_LAST_PRESS_EN
    if (key_state_q[last_q]) key_code_d = last_q;
    else                     key_code_d = lowest_idx(key_state_q);
`else
    key_code_d = lowest_idx(key_state_q);
`endif
  end

  // State registers
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      for (int i = 0; i < KEY_NUM; i++) db_q[i] <= 4'd0;
      key_state_q <= '0;
      chg_q       <= '0;
      walk_busy_q <= 1'b0;
      walk_idx_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
`ifdef KEYBOARD_LAST_PRESS_EN
      last_q      <= '0;
`endif
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      db_q        <= db_d;
      key_state_q <= key_state_d;
      chg_q       <= chg_d;
      walk_busy_q <= walk_busy_d;
      walk_idx_q  <= walk_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      evt_valid_q <= (count_d != '0);
      overflow_q  <= overflow_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
`ifdef KEYBOARD_LAST_PRESS_EN
      last_q      <= last_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care until written, pointers define validity
  always_ff @(posedge pclk) begin
    if (wr_en_s) mem_q[wr_ptr_q] <= push_data_s;
  end

  assign key_state = key_state_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = mem_q[rd_ptr_q][EW-1:1];
  assign evt_press = mem_q[rd_ptr_q][0];
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_keyboard_scan.sv
// tb_keyboard_scan: directed bench for keyboard_scan at 1000 pclk cycles per scan tick.
`timescale 1ns/1ps
module tb_keyboard_scan;

  localparam int KN = 13;

  logic          pclk = 1'b0;
  logic          rst = 1'b1;
  logic [KN-1:0] key = '1;
  logic [KN-1:0] key_state;
  logic          key_valid;
  logic [3:0]    key_code;
  logic          evt_valid;
  logic          evt_ready = 1'b0;
  logic [3:0]    evt_code;
  logic          evt_press;
  logic          overflow;
  int            cyc;
  int            n_checks = 0;
  int            n_errors = 0;
  logic [3:0]    exp_code;

  keyboard_scan #(
    .PCLK_FREQ(10_000_000), .SCAN_FREQ(10_000), .KEY_NUM(KN),
    .DEBOUNCE_CNT(4), .FIFO_DEPTH(8)
  ) dut (
    .pclk(pclk), .rst(rst), .key(key), .key_state(key_state),
    .key_valid(key_valid), .key_code(key_code), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_code(evt_code), .evt_press(evt_press),
    .overflow(overflow)
  );

  always #5 pclk = ~pclk;

  // Cycles since reset release; tick edges fall on multiples of 1000
  always @(posedge pclk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt_ready = 1'b0;
    key = '1;
    repeat (3) @(posedge pclk);
    #1;
    check_val("rst key_state", 32'(key_state), 32'd0);
    check_val("rst key_valid", 32'(key_valid), 32'd0);
    check_val("rst key_code",  32'(key_code),  32'd0);
    check_val("rst evt_valid", 32'(evt_valid), 32'd0);
    check_val("rst overflow",  32'(overflow),  32'd0);
    @(negedge pclk);
    rst = 1'b0;
  endtask

  task automatic pop_check(input string tag, input int code, input logic press);
    check_val({tag, " valid"}, 32'(evt_valid), 32'd1);
    check_val({tag, " code"},  32'(evt_code),  32'(code));
    check_val({tag, " press"}, 32'(evt_press), 32'(press));
    evt_ready = 1'b1;
    @(posedge pclk);
    #1;
    evt_ready = 1'b0;
  endtask

  initial begin
    // Single key press and release on key 0
    do_reset();
    run_to(100);  key = ~13'h0001;
    run_to(3999); check_val("k0 before tick4", 32'(key_state), 32'h0000);
    run_to(4000);
    check_val("k0 state", 32'(key_state), 32'h0001);
    check_val("k0 valid lag", 32'(key_valid), 32'd0);
    check_val("k0 evt not yet", 32'(evt_valid), 32'd0);
    run_to(4001);
    check_val("k0 key_valid", 32'(key_valid), 32'd1);
    check_val("k0 key_code", 32'(key_code), 32'd0);
    pop_check("k0 press", 0, 1'b1);
    check_val("k0 fifo empty", 32'(evt_valid), 32'd0);
    run_to(4100); key = '1;
    run_to(8000); check_val("k0 released", 32'(key_state), 32'h0000);
    run_to(8001);
    check_val("k0 rel key_valid", 32'(key_valid), 32'd0);
    pop_check("k0 release", 0, 1'b0);

    // Two-tick glitch on key 5 must be filtered
    do_reset();
    run_to(100);  key = ~13'h0020;
    run_to(2100); key = '1;
    run_to(6001);
    check_val("glitch state", 32'(key_state), 32'h0000);
    check_val("glitch evt", 32'(evt_valid), 32'd0);

    // Keys 3 and 9 in the same tick
    do_reset();
    run_to(100);  key = ~13'h0208;
    run_to(4000); check_val("k3k9 state", 32'(key_state), 32'h0208);
`ifdef KEYBOARD_LAST_PRESS_EN
    exp_code = 4'd9;
`else
    exp_code = 4'd3;
`endif
    run_to(4001); check_val("k3k9 key_code", 32'(key_code), 32'(exp_code));
    run_to(4015); check_val("k3k9 head held", 32'(evt_code), 32'd3);
    pop_check("k3k9 first", 3, 1'b1);
    pop_check("k3k9 second", 9, 1'b1);
    check_val("k3k9 empty", 32'(evt_valid), 32'd0);
    run_to(4100); key = ~13'h0200;
    run_to(8001); check_val("k9 only code", 32'(key_code), 32'd9);

    // Full FIFO: simultaneous push/pop, then a dropped event
    do_reset();
    run_to(100);  key = ~13'h01FF;
    run_to(4008); evt_ready = 1'b1;
    run_to(4009); evt_ready = 1'b0;
    check_val("full pushpop ovf", 32'(overflow), 32'd0);
    for (int i = 1; i <= 8; i++) pop_check("full press", i, 1'b1);
    check_val("full drained", 32'(evt_valid), 32'd0);
    run_to(4100); key = '1;
    run_to(8008); check_val("ovf before drop", 32'(overflow), 32'd0);
    run_to(8009); check_val("ovf after drop", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) pop_check("ovf release", i, 1'b0);
    check_val("ovf drained", 32'(evt_valid), 32'd0);
    check_val("ovf sticky", 32'(overflow), 32'd1);

    // Reset while the walker is serialising
    do_reset();
    run_to(100);  key = '0;
    run_to(4005); check_val("mid walk evt", 32'(evt_valid), 32'd1);
    rst = 1'b1;
    key = '1;
    @(posedge pclk);
    #1;
    check_val("midrst key_state", 32'(key_state), 32'd0);
    check_val("midrst key_valid", 32'(key_valid), 32'd0);
    check_val("midrst key_code",  32'(key_code),  32'd0);
    check_val("midrst evt_valid", 32'(evt_valid), 32'd0);
    check_val("midrst overflow",  32'(overflow),  32'd0);
    @(negedge pclk);
    rst = 1'b0;
    run_to(5000);
    check_val("post rst no evt", 32'(evt_valid), 32'd0);
    check_val("post rst state", 32'(key_state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
